// File: rtl/lcd_pixel_feeder.sv
// Pixel prefetcher for the LCD timing generator: fetches fixed-size bursts from
// frame memory into a local FIFO and pops one RGB565 word per lcd_read strobe.
module lcd_pixel_feeder #(
  parameter int          ADDR_W        = 21,
  parameter int          FRAME_PIXELS  = 307200,
  parameter int          FIFO_DEPTH    = 64,
  parameter int          BURST         = 16,
  parameter logic [15:0] UNDERFLOW_PIX = 16'hF800
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          lcd_read,
  output logic [15:0]                   lcd_readdata,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [15:0]                   mem_rdata,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_t;

  state_t            state;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    reserved;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [ADDR_W-1:0] fetch_next;
  logic              do_push;
  logic              do_pop;
  logic              rvalid_ok;
  logic              room;
  logic              last_word;

  always_comb begin
    // NOTE: combinational outputs get a value on every path, so no latch is inferred.
    rvalid_ok  = mem_rvalid && (state == RECV || state == DRAIN);
    do_push    = mem_rvalid && (state == RECV) && !frame_start;
    do_pop     = lcd_read && !frame_start && (fifo_level != '0);
    last_word  = rvalid_ok && (reserved == (PTR_W+1)'(1));
    room       = ({1'b0, fifo_level} + {1'b0, reserved}) <= (PTR_W+2)'(FIFO_DEPTH - BURST);
    fetch_next = (fetch_ptr >= ADDR_W'(FRAME_PIXELS - BURST)) ? '0
                                                               : fetch_ptr + ADDR_W'(BURST);
  end

  // Burst fetch control; only one burst is ever outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      reserved  <= '0;
      fetch_ptr <= '0;
    end else begin
      if (rvalid_ok) reserved <= reserved - (PTR_W+1)'(1);
      unique case (state)
        IDLE: begin
          if (!frame_start && room) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_ptr;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            // A grant that coincides with frame_start still delivers a burst.
            reserved  <= (PTR_W+1)'(BURST);
            fetch_ptr <= fetch_next;
            mem_req   <= 1'b0;
            state     <= frame_start ? DRAIN : RECV;
          end else if (frame_start) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        RECV: begin
          if (last_word)        state <= IDLE;
          else if (frame_start) state <= DRAIN;
        end
        DRAIN: begin
          if (last_word) state <= IDLE;
        end
      endcase
      if (frame_start) fetch_ptr <= '0;
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and level alone define its contents.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      lcd_readdata <= '0;
      underflow    <= 1'b0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      underflow  <= 1'b0;
      if (lcd_read) lcd_readdata <= UNDERFLOW_PIX;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        lcd_readdata <= fifo_mem[rd_ptr];
        rd_ptr       <= rd_ptr + PTR_W'(1);
      end else if (lcd_read) begin
        lcd_readdata <= UNDERFLOW_PIX;
        underflow    <= 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + (PTR_W+1)'(1);
        2'b01:   fifo_level <= fifo_level - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Self-checking bench: a full-size feeder plus a 64-pixel-frame feeder for the
// address wrap, each served by a simple burst memory model.
module tb_lcd_pixel_feeder;

  logic        clk;
  logic        reset;
  logic        frame_start, lcd_read;
  logic [15:0] lcd_readdata;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;
  logic        underflow;
  logic [6:0]  fifo_level;

  logic        s_frame_start, s_lcd_read;
  logic [15:0] s_lcd_readdata;
  logic        s_mem_req;
  logic [20:0] s_mem_addr;
  logic        s_mem_gnt, s_mem_rvalid;
  logic [15:0] s_mem_rdata;
  logic        s_underflow;
  logic [6:0]  s_fifo_level;

  bit          mem_auto;
  bit          mem_stall;
  logic        man_gnt, man_rvalid;
  logic [15:0] man_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        fs, rd, gnt, rv;
    logic [15:0] rdata;
    logic [15:0] exp_data;
    logic        exp_req;
    logic        exp_uf;
    int          exp_lvl;
  } vec_t;

  vec_t vecs[$];

  lcd_pixel_feeder dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .lcd_read(lcd_read),
    .lcd_readdata(lcd_readdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  lcd_pixel_feeder #(.FRAME_PIXELS(64)) dut_small (
    .clk(clk), .reset(reset), .frame_start(s_frame_start), .lcd_read(s_lcd_read),
    .lcd_readdata(s_lcd_readdata), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
    .mem_gnt(s_mem_gnt), .mem_rvalid(s_mem_rvalid), .mem_rdata(s_mem_rdata),
    .underflow(s_underflow), .fifo_level(s_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: grant after the request has waited 2 cycles, then 16
  // back-to-back words whose value is their own address.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic        gnt, rvalid;
    logic [15:0] rdata;
    logic        req_s, hold;
    logic [20:0] addr_s;
    logic [20:0] base;
    logic [20:0] gaddr [16];
    int          grants;

    assign req_s  = (g == 0) ? mem_req : s_mem_req;
    assign addr_s = (g == 0) ? mem_addr : s_mem_addr;
    assign hold   = (g == 0) && (mem_stall || !mem_auto);

    initial begin
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; grants = 0; base = '0;
      forever begin
        @(negedge clk);
        if (req_s && !hold) begin
          @(negedge clk);
          @(negedge clk);
          if (req_s) begin
            gnt  = 1'b1;
            base = addr_s;
            if (grants < 16) gaddr[grants] = addr_s;
            grants++;
            @(negedge clk);
            gnt = 1'b0;
            for (int i = 0; i < 16; i++) begin
              rvalid = 1'b1;
              rdata  = base[15:0] + 16'(i);
              @(negedge clk);
            end
            rvalid = 1'b0;
          end
        end
      end
    end
  end

  assign mem_gnt      = mem_auto ? g_mem[0].gnt    : man_gnt;
  assign mem_rvalid   = mem_auto ? g_mem[0].rvalid : man_rvalid;
  assign mem_rdata    = mem_auto ? g_mem[0].rdata  : man_rdata;
  assign s_mem_gnt    = g_mem[1].gnt;
  assign s_mem_rvalid = g_mem[1].rvalid;
  assign s_mem_rdata  = g_mem[1].rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fs, input logic rd, input logic gnt, input logic rv,
                     input logic [15:0] rdata, input logic [15:0] exp_data,
                     input logic exp_req, input logic exp_uf, input int exp_lvl);
    vec_t v;
    v.fs = fs; v.rd = rd; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.exp_data = exp_data; v.exp_req = exp_req; v.exp_uf = exp_uf; v.exp_lvl = exp_lvl;
    vecs.push_back(v);
  endtask

  // Bounded wait for the full-size FIFO to fill with no request pending.
  task automatic wait_full(input string name);
    int c;
    c = 0;
    while (!(fifo_level == 7'd64 && !mem_req) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(name, fifo_level, 64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int issued;
    int exp5 [5];
    exp5 = '{0, 16, 32, 48, 0};

    reset = 1'b1; frame_start = 1'b0; lcd_read = 1'b0;
    s_frame_start = 1'b0; s_lcd_read = 1'b0;
    mem_auto = 1'b0; mem_stall = 1'b0;
    man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

    // Reset state.
    @(negedge clk);
    check("rst_readdata", lcd_readdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_underflow", underflow, 0);
    check("rst_level", fifo_level, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_auto = 1'b1;

    // Initial prefetch: four bursts then idle.
    wait_full("t1_fill");
    check("t1_grants", g_mem[0].grants, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t1_addr%0d", k), g_mem[0].gaddr[k], 16 * k);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t1_req_idle", mem_req, 0);
    end
    check("t1_level", fifo_level, 64);

    // 640 pixels in order, reads paced at 3 of every 4 cycles.
    issued = 0;
    for (int c = 0; issued < 640; c++) begin
      lcd_read = (c % 4 != 3);
      @(negedge clk);
      if (lcd_read) begin
        check($sformatf("t2_pix%0d", issued), lcd_readdata, 16'(issued));
        issued++;
      end
    end
    lcd_read = 1'b0;
    check("t2_underflow", underflow, 0);

    // Memory stall while the reader keeps popping.
    wait_full("t3_fill");
    mem_stall = 1'b1;
    for (int i = 0; i < 70; i++) begin
      lcd_read = 1'b1;
      @(negedge clk);
      if (i < 64) check($sformatf("t3_pix%0d", i), lcd_readdata, 640 + i);
      else        check($sformatf("t3_under%0d", i), lcd_readdata, 16'hF800);
      check($sformatf("t3_uf%0d", i), underflow, (i >= 64) ? 1 : 0);
    end
    lcd_read = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_uf_sticky", underflow, 1);
    check("t3_data_hold", lcd_readdata, 16'hF800);
    check("t3_req_pending", mem_req, 1);
    check("t3_req_addr", mem_addr, 704);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("t3_fs_uf", underflow, 0);
    check("t3_fs_level", fifo_level, 0);
    check("t3_fs_req_drop", mem_req, 0);
    @(negedge clk);
    check("t3_rereq", mem_req, 1);
    check("t3_rereq_addr", mem_addr, 0);
    mem_stall = 1'b0;
    wait_full("t3_refill");
    mem_auto = 1'b0;

    // Directed vectors: push/pop corners, frame_start mid-burst, frame_start with grant.
    add(1, 1, 0, 0, 16'h0000, 16'hF800, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hF800, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'hF800, 1, 1, 0);
    add(0, 0, 1, 0, 16'h0000, 16'hF800, 0, 1, 0);
    add(0, 1, 0, 1, 16'd100,  16'hF800, 0, 1, 1);
    add(0, 1, 0, 1, 16'd101,  16'd100,  0, 1, 1);
    for (int k = 2; k <= 8; k++) add(0, 0, 0, 1, 16'(100 + k), 16'd100, 0, 1, k);
    add(1, 1, 0, 0, 16'h0000, 16'hF800, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 0, 1, 16'hBEEF, 16'hF800, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hF800, 1, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'hF800, 1, 1, 0);
    add(1, 1, 1, 0, 16'h0000, 16'hF800, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 0, 0, 1, 16'h1234, 16'hF800, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'hF800, 1, 0, 0);
    add(0, 0, 0, 1, 16'h7777, 16'hF800, 1, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'hF800, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0055, 16'hF800, 0, 0, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h0055, 0, 0, 0);

    foreach (vecs[i]) begin
      frame_start = vecs[i].fs;
      lcd_read    = vecs[i].rd;
      man_gnt     = vecs[i].gnt;
      man_rvalid  = vecs[i].rv;
      man_rdata   = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d_data", i), lcd_readdata, vecs[i].exp_data);
      check($sformatf("v%0d_req", i), mem_req, vecs[i].exp_req);
      check($sformatf("v%0d_uf", i), underflow, vecs[i].exp_uf);
      check($sformatf("v%0d_level", i), fifo_level, vecs[i].exp_lvl);
      if (vecs[i].exp_req) check($sformatf("v%0d_addr", i), mem_addr, 0);
    end
    frame_start = 1'b0; lcd_read = 1'b0;
    man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

    // Frame wrap on the 64-pixel feeder.
    issued = 0;
    for (int c = 0; issued < 80; c++) begin
      s_lcd_read = (c % 2 == 0);
      @(negedge clk);
      if (s_lcd_read) begin
        check($sformatf("t5_pix%0d", issued), s_lcd_readdata, issued % 64);
        issued++;
      end
    end
    s_lcd_read = 1'b0;
    check("t5_grants_ge5", (g_mem[1].grants >= 5) ? 1 : 0, 1);
    for (int k = 0; k < 5; k++) check($sformatf("t5_addr%0d", k), g_mem[1].gaddr[k], exp5[k]);
    check("t5_underflow", s_underflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
